// File: rtl/falling_sand_pkg.sv
// Shared types and sizing for the falling sand game datapath.
// Screen geometry, VRAM sizing and the write arbiter state encoding.
package falling_sand_pkg;

    localparam int ACTIVE_COLUMNS  = 640;
    localparam int ACTIVE_ROWS     = 480;
    localparam int VRAM_ADDR_WIDTH =
        $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS);
    localparam int DATA_WIDTH      = 1;

    typedef enum logic {
        PRI0   = 1'b0,
        FORCE1 = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of cycles port 1 waited with a pending write.
// Flags when the next count value reaches the starvation limit.
module arb_starve_counter #(
    parameter int LIMIT = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic reach_limit_o
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over increment; the count sticks at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
        reach_limit_o = (cnt_d == LIM);
    end

    // Count register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Two-port write arbiter for the shared VRAM / game-state RAM port.
// Port 0 has priority; a starved port 1 gets one forced grant.
module vram_write_arbiter
    import falling_sand_pkg::*;
#(
    parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = falling_sand_pkg::DATA_WIDTH,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req0_valid_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    output logic                  req1_ready_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  starved_o
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic                  wr_en_q;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] wr_data_d;

    logic ready0;
    logic ready1;
    logic xfer0;
    logic xfer1;
    logic cnt_inc;
    logic cnt_clr;
    logic reach_limit;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .inc_i         (cnt_inc),
        .clr_i         (cnt_clr),
        .reach_limit_o (reach_limit)
    );

    // Grant selection and next state; nothing is granted in reset.
    always_comb begin
        ready0  = 1'b0;
        ready1  = 1'b0;
        state_d = state_q;
        if (!reset_i) begin
            unique case (state_q)
                PRI0: begin
                    ready0 = req0_valid_i;
                    ready1 = req1_valid_i & ~req0_valid_i;
                    if (req1_valid_i && !ready1 && reach_limit) begin
                        state_d = FORCE1;
                    end
                end
                FORCE1: begin
                    ready1 = req1_valid_i;
                    if (!req1_valid_i || ready1) begin
                        state_d = PRI0;
                    end
                end
            endcase
        end
    end

    // Transfers, counter control and the next RAM write.
    always_comb begin
        xfer0     = req0_valid_i & ready0;
        xfer1     = req1_valid_i & ready1;
        cnt_inc   = req1_valid_i & ~ready1;
        cnt_clr   = ~req1_valid_i | xfer1;
        wr_en_d   = xfer0 | xfer1;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (xfer0) begin
            wr_addr_d = req0_addr_i;
            wr_data_d = req0_data_i;
        end else if (xfer1) begin
            wr_addr_d = req1_addr_i;
            wr_data_d = req1_data_i;
        end
    end

    // State and registered RAM write port.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= PRI0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign req0_ready_o = ready0;
    assign req1_ready_o = ready1;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign starved_o    = (state_q == FORCE1);

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter with STARVE_LIMIT = 3.
// Expected values are hand-derived per scenario.
module tb_vram_write_arbiter;

    localparam int AW = 19;
    localparam int DW = 1;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          v0, v1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          ready0, ready1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          starved;

    int n_chk = 0;
    int n_err = 0;

    logic          ram5 = 1'b0;
    logic          f;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;

    always #5 clk = ~clk;

    vram_write_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (3)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req0_valid_i (v0),
        .req0_addr_i  (a0),
        .req0_data_i  (d0),
        .req0_ready_o (ready0),
        .req1_valid_i (v1),
        .req1_addr_i  (a1),
        .req1_data_i  (d1),
        .req1_ready_o (ready1),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .starved_o    (starved)
    );

    // Tiny RAM model for the one address shared by both ports.
    always @(posedge clk) begin
        if (wr_en && wr_addr == 19'h00005) ram5 <= wr_data[0];
    end

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        v0 = 1'b1; v1 = 1'b1;
        a0 = 19'h7; a1 = 19'h9;
        d0 = 1'b1; d1 = 1'b1;

        // 1: reset holds everything low even with both valids up
        #1;
        chk("rst_rdy0", ready0, 0);
        chk("rst_rdy1", ready1, 0);
        chk("rst_wen", wr_en, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_starv", starved, 0);
        cyc();
        chk("rst_rdy0_clk", ready0, 0);
        v0 = 1'b0; v1 = 1'b0;
        reset_i = 1'b0;
        cyc();

        // 2: solo port 1
        v1 = 1'b1; a1 = 19'h12C00; d1 = 1'b1;
        #1;
        chk("t2_rdy1", ready1, 1);
        chk("t2_rdy0", ready0, 0);
        cyc();
        v1 = 1'b0;
        chk("t2_wen", wr_en, 1);
        chk("t2_addr", wr_addr, 19'h12C00);
        chk("t2_data", wr_data, 1);
        cyc();
        chk("t2_wen_off", wr_en, 0);
        chk("t2_addr_hold", wr_addr, 19'h12C00);
        chk("t2_data_hold", wr_data, 1);

        // 3: contention gives a 3:1 pattern
        v0 = 1'b1; v1 = 1'b1; d0 = 1'b0; d1 = 1'b1;
        a1 = 19'h200;
        for (int c = 0; c < 8; c++) begin
            a0 = 19'h100 + AW'(c);
            f = (c % 4 == 3);
            #1;
            chk("t3_rdy0", ready0, 32'(!f));
            chk("t3_rdy1", ready1, 32'(f));
            chk("t3_starv", starved, 32'(f));
            ea = f ? a1 : a0;
            ed = f ? d1 : d0;
            cyc();
            chk("t3_wen", wr_en, 1);
            chk("t3_addr", wr_addr, ea);
            chk("t3_data", wr_data, ed);
            if (f) a1 = a1 + 1'b1;
        end
        v0 = 1'b0; v1 = 1'b0;
        cyc();

        // 4: withdrawing valid1 at cnt 2 clears the count
        v0 = 1'b1; v1 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            v1 = (c != 2);
            f = (c == 6);
            #1;
            chk("t4_starv", starved, 32'(f));
            chk("t4_rdy0", ready0, 32'(!f));
            chk("t4_rdy1", ready1, 32'(f));
            cyc();
        end
        v0 = 1'b0; v1 = 1'b0;
        cyc();

        // 5: same address from both ports, port 0 first
        v0 = 1'b1; a0 = 19'h5; d0 = 1'b0;
        v1 = 1'b1; a1 = 19'h5; d1 = 1'b1;
        #1;
        chk("t5_rdy0", ready0, 1);
        chk("t5_rdy1", ready1, 0);
        cyc();
        v0 = 1'b0;
        chk("t5_wen0", wr_en, 1);
        chk("t5_addr0", wr_addr, 19'h5);
        chk("t5_data0", wr_data, 0);
        #1;
        chk("t5_rdy1b", ready1, 1);
        cyc();
        v1 = 1'b0;
        chk("t5_wen1", wr_en, 1);
        chk("t5_addr1", wr_addr, 19'h5);
        chk("t5_data1", wr_data, 1);
        cyc();
        chk("t5_wen_off", wr_en, 0);
        chk("t5_ram", ram5, 1);

        // 6: async reset in FORCE1 with a write registered
        v0 = 1'b1; a0 = 19'h300; d0 = 1'b1;
        v1 = 1'b1; a1 = 19'h3FF; d1 = 1'b1;
        cyc(); cyc(); cyc();
        chk("t6_starv", starved, 1);
        chk("t6_wen", wr_en, 1);
        chk("t6_addr", wr_addr, 19'h300);
        #2;
        reset_i = 1'b1;
        #1;
        chk("t6_wen_rst", wr_en, 0);
        chk("t6_addr_rst", wr_addr, 0);
        chk("t6_data_rst", wr_data, 0);
        chk("t6_starv_rst", starved, 0);
        chk("t6_rdy0_rst", ready0, 0);
        chk("t6_rdy1_rst", ready1, 0);
        cyc();
        chk("t6_wen_hold", wr_en, 0);
        reset_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            f = (c == 3);
            #1;
            chk("t6_post_starv", starved, 32'(f));
            chk("t6_post_rdy0", ready0, 32'(!f));
            chk("t6_post_rdy1", ready1, 32'(f));
            cyc();
        end
        v0 = 1'b0; v1 = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
